// File: rtl/axi_ram_slave_if.sv
// AXI3 32-bit bus bundle for axi_ram_slave: ar/r/aw/w/b channels.
// The master modport drives requests, the slave modport answers them.
interface axi_ram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI3 32-bit RAM responder: one outstanding read and one outstanding write,
// served by independent read and write FSMs over a word-organised memory.
module axi_ram_slave #(
    parameter int    ADDR_WIDTH = 14,
    parameter string INIT_FILE  = ""
) (
    input  logic aclk,
    input  logic aresetn,
    axi_ram_slave_if.slave bus
);
    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IW;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } burst_t;

    logic [31:0] mem [0:DEPTH-1];

    // Address of the following beat; an illegal WRAP length behaves as INCR.
    function automatic logic [31:0] next_addr(input burst_t b);
        logic [31:0] step;
        logic [31:0] span;
        step = 32'd1 << b.size;
        span = ({28'd0, b.len} + 32'd1) << b.size;
        case (b.burst)
            2'd0:    next_addr = b.addr;
            2'd2:    if (b.len == 4'd1 || b.len == 4'd3 || b.len == 4'd7 || b.len == 4'd15)
                         next_addr = (b.addr & ~(span - 32'd1)) | ((b.addr + step) & (span - 32'd1));
                     else
                         next_addr = b.addr + step;
            default: next_addr = b.addr + step;
        endcase
    endfunction

    // ---------------- read channel ----------------
    logic [0:0]  r_state;
    burst_t      r_b;
    logic [3:0]  r_cnt;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [31:0] r_next;
    logic        ar_hs, r_hs, r_last;

    assign r_next = next_addr(r_b);
    assign ar_hs  = bus.arvalid && bus.arready;
    assign r_hs   = bus.rvalid && bus.rready;
    assign r_last = (r_cnt == r_b.len);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            r_b     <= '0;
            r_cnt   <= '0;
            r_id    <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    r_b     <= '{addr: bus.araddr, len: bus.arlen, size: bus.arsize, burst: bus.arburst};
                    r_cnt   <= '0;
                    r_id    <= bus.arid;
                    r_data  <= mem[bus.araddr[ADDR_WIDTH-1:2]];
                    r_state <= R_DATA;
                end
                default: if (r_hs) begin
                    if (r_last) begin
                        r_state <= R_IDLE;
                    end else begin
                        r_b.addr <= r_next;
                        r_cnt    <= r_cnt + 4'd1;
                        r_data   <= mem[r_next[ADDR_WIDTH-1:2]];
                    end
                end
            endcase
        end
    end

    assign bus.arready = (r_state == R_IDLE) && aresetn;
    assign bus.rvalid  = (r_state == R_DATA);
    assign bus.rlast   = (r_state == R_DATA) && r_last;
    assign bus.rid     = r_id;
    assign bus.rdata   = r_data;
    assign bus.rresp   = 2'b00;

    // ---------------- write channel ----------------
    logic [1:0]    w_state;
    burst_t        w_b;
    logic [3:0]    w_cnt;
    logic [3:0]    w_id;
    logic          w_err;
    logic [31:0]   w_next;
    logic [IW-1:0] w_idx;
    logic          aw_hs, w_hs, w_last;

    assign w_next = next_addr(w_b);
    assign w_idx  = w_b.addr[ADDR_WIDTH-1:2];
    assign aw_hs  = bus.awvalid && bus.awready;
    assign w_hs   = bus.wvalid && bus.wready;
    assign w_last = (w_cnt == w_b.len);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            w_b     <= '0;
            w_cnt   <= '0;
            w_id    <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    w_b     <= '{addr: bus.awaddr, len: bus.awlen, size: bus.awsize, burst: bus.awburst};
                    w_cnt   <= '0;
                    w_id    <= bus.awid;
                    w_err   <= 1'b0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    // wlast must mark exactly the len-th beat; data lands either way
                    w_err    <= w_err | (w_last ? !bus.wlast : bus.wlast);
                    w_b.addr <= w_next;
                    w_cnt    <= w_cnt + 4'd1;
                    if (w_last) w_state <= W_RESP;
                end
                W_RESP: if (bus.bready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs) begin
            for (int i = 0; i < 4; i++)
                if (bus.wstrb[i]) mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
    end

    assign bus.awready = (w_state == W_IDLE) && aresetn;
    assign bus.wready  = (w_state == W_DATA);
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bid     = w_id;
    assign bus.bresp   = w_err ? 2'b10 : 2'b00;

    logic unused_bits;
    assign unused_bits = ^{bus.arlock, bus.arcache, bus.arprot, bus.awlock, bus.awcache,
                           bus.awprot, bus.wid, r_next, w_next};
endmodule

// File: tb/tb_axi_ram_slave.sv
// Randomised self-checking bench for axi_ram_slave against an array-based
// memory model that computes beat addresses in closed form.
module tb_axi_ram_slave;
    localparam int AW    = 14;
    localparam int DEPTH = 1 << (AW - 2);

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_ram_slave_if bus();

    axi_ram_slave #(.ADDR_WIDTH(AW)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [15:0] wl_mask;
    int          rr_mode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // k-th beat address of a burst, straight from the burst rules
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                              input int size, input int burst, input int k);
        int unsigned step, span;
        logic [31:0] off;
        step = 32'd1 << size;
        if (burst == 0) return a;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            span = (len + 1) * step;
            off  = ((a % span) + k * step) % span;
            return a - (a % span) + off;
        end
        return a + k * step;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int bdly);
        int beat = 0;
        int cyc = 0;
        bit aw_hs, w_hs;
        int ix;
        logic [1:0] exp_resp;
        exp_resp = (wl_mask == (16'd1 << len)) ? 2'b00 : 2'b10;
        @(negedge aclk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        bus.wid = id; bus.wdata = wd[0]; bus.wstrb = ws[0]; bus.wlast = wl_mask[0];
        bus.wvalid = 1'b1;
        bus.bready = 1'b0;
        while (beat <= int'(len) && cyc < 500) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(negedge aclk);
            cyc++;
            if (aw_hs) bus.awvalid = 1'b0;
            if (w_hs) begin
                ix = widx(beat_addr(addr, len, size, burst, beat));
                for (int i = 0; i < 4; i++)
                    if (ws[beat][i]) ref_mem[ix][8*i +: 8] = wd[beat][8*i +: 8];
                beat++;
                if (beat <= int'(len)) begin
                    bus.wdata = wd[beat]; bus.wstrb = ws[beat]; bus.wlast = wl_mask[beat];
                end
            end
            bus.wvalid = (beat <= int'(len)) ? ($urandom_range(0, 3) != 0) : 1'b0;
        end
        chk("w_timeout", 32'(cyc < 500), 32'd1);
        cyc = 0;
        while (!bus.bvalid && cyc < 50) begin
            @(negedge aclk);
            cyc++;
        end
        chk("b_valid", 32'(bus.bvalid), 32'd1);
        chk("b_resp", 32'(bus.bresp), 32'(exp_resp));
        chk("b_id", 32'(bus.bid), 32'(id));
        if (bdly > 0) begin
            repeat (bdly) @(negedge aclk);
            chk("b_hold", 32'(bus.bvalid), 32'd1);
        end
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        chk("b_drop", 32'(bus.bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input string tag);
        int beat = 0;
        int cyc = 0;
        bit ar_hs, r_hs;
        logic [31:0] exp;
        @(negedge aclk);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        bus.rready = 1'b1;
        while (beat <= int'(len) && cyc < 500) begin
            ar_hs = bus.arvalid && bus.arready;
            r_hs  = bus.rvalid && bus.rready;
            if (bus.rvalid) begin
                exp = ref_mem[widx(beat_addr(addr, len, size, burst, beat))];
                chk({tag, "_data"}, bus.rdata, exp);
                chk({tag, "_last"}, 32'(bus.rlast), 32'(beat == int'(len)));
                chk({tag, "_id"}, 32'(bus.rid), 32'(id));
                chk({tag, "_arbusy"}, 32'(bus.arready), 32'd0);
            end
            @(negedge aclk);
            cyc++;
            if (ar_hs) begin
                bus.arvalid = 1'b0;
                chk({tag, "_lat"}, 32'(bus.rvalid), 32'd1);
            end
            if (r_hs) beat++;
            case (rr_mode)
                0:       bus.rready = 1'b1;
                1:       bus.rready = ~bus.rready;
                default: bus.rready = 1'($urandom_range(0, 1));
            endcase
        end
        chk({tag, "_timeout"}, 32'(cyc < 500), 32'd1);
        bus.rready = 1'b0;
        chk({tag, "_done"}, 32'(bus.rvalid), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  id, len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] addr;
        logic [16:0] m;

        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        rr_mode = 0;

        // reset with requests pending
        bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.rready = 1'b1;
        repeat (3) @(negedge aclk);
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_wready",  32'(bus.wready),  32'd0);
        chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
        chk("rst_rlast",   32'(bus.rlast),   32'd0);
        chk("rst_rdata",   bus.rdata,        32'd0);
        chk("rst_bresp",   32'(bus.bresp),   32'd0);
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.rready = 1'b0;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("post_arready", 32'(bus.arready), 32'd1);
        chk("post_awready", 32'(bus.awready), 32'd1);

        // fill the whole RAM so every later read has a known model value
        for (int b = 0; b < DEPTH / 16; b++) begin
            for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
            wl_mask = 16'h8000;
            axi_write(4'(b), 32'(b * 64), 4'd15, 3'd2, 2'd1, 0);
        end

        // single-beat write/read at an aliased address
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl_mask = 16'h0001;
        axi_write(4'd5, 32'h1FC00000, 4'd0, 3'd2, 2'd1, 2);
        axi_read(4'd9, 32'h1FC00000, 4'd0, 3'd2, 2'd1, "single");

        // INCR 8 beats, rready toggling
        for (int k = 0; k < 8; k++) begin wd[k] = 32'(k); ws[k] = 4'hF; end
        wl_mask = 16'h0080;
        axi_write(4'd1, 32'h100, 4'd7, 3'd2, 2'd1, 0);
        rr_mode = 1;
        axi_read(4'd2, 32'h100, 4'd7, 3'd2, 2'd1, "incr8");

        // WRAP 4 from 0x108 over A,B,C,D
        wd[0] = 32'hAAAA0000; wd[1] = 32'hBBBB1111; wd[2] = 32'hCCCC2222; wd[3] = 32'hDDDD3333;
        for (int k = 0; k < 4; k++) ws[k] = 4'hF;
        wl_mask = 16'h0008;
        axi_write(4'd3, 32'h100, 4'd3, 3'd2, 2'd1, 0);
        rr_mode = 0;
        axi_read(4'd4, 32'h108, 4'd3, 3'd2, 2'd2, "wrap4");

        // byte strobes
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF; wl_mask = 16'h0001;
        axi_write(4'd6, 32'h200, 4'd0, 3'd2, 2'd1, 0);
        wd[0] = 32'h11223344; ws[0] = 4'h5;
        axi_write(4'd6, 32'h200, 4'd0, 3'd2, 2'd1, 1);
        axi_read(4'd6, 32'h200, 4'd0, 3'd2, 2'd1, "strb");

        // early wlast -> SLVERR, both beats still written
        wd[0] = 32'h0BAD0001; wd[1] = 32'h0BAD0002; ws[0] = 4'hF; ws[1] = 4'hF;
        wl_mask = 16'h0001;
        axi_write(4'd7, 32'h300, 4'd1, 3'd2, 2'd1, 0);
        axi_read(4'd7, 32'h300, 4'd1, 3'd2, 2'd1, "wlast_early");
        // missing wlast on final beat
        wd[0] = 32'h5A5A5A5A; wl_mask = 16'h0000;
        axi_write(4'd8, 32'h310, 4'd0, 3'd2, 2'd1, 0);

        // concurrent AR and AW
        for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        wl_mask = 16'h0008;
        fork
            axi_write(4'hA, 32'h400, 4'd3, 3'd2, 2'd1, 0);
            axi_read(4'hB, 32'h800, 4'd3, 3'd2, 2'd1, "conc");
            begin
                @(negedge aclk); #1;
                chk("conc_ar_acc", 32'(bus.arvalid && bus.arready), 32'd1);
                chk("conc_aw_acc", 32'(bus.awvalid && bus.awready), 32'd1);
            end
        join
        axi_read(4'hC, 32'h400, 4'd3, 3'd2, 2'd1, "conc_back");

        // reset in the middle of a read burst keeps RAM contents
        @(negedge aclk);
        bus.arid = 4'd1; bus.araddr = 32'h100; bus.arlen = 4'd7; bus.arsize = 3'd2; bus.arburst = 2'd1;
        bus.arvalid = 1'b1; bus.rready = 1'b0;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        @(negedge aclk);
        chk("mid_rvalid", 32'(bus.rvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        axi_read(4'd2, 32'h100, 4'd7, 3'd2, 2'd1, "after_rst");

        // randomized bursts
        for (int t = 0; t < 40; t++) begin
            id    = 4'($urandom);
            burst = 2'($urandom_range(0, 2));
            size  = 3'($urandom_range(0, 2));
            if (burst == 2'd2) begin
                case ($urandom_range(0, 4))
                    0: len = 4'd1; 1: len = 4'd3; 2: len = 4'd7; 3: len = 4'd15;
                    default: len = 4'd2;
                endcase
            end else begin
                len = 4'($urandom_range(0, 15));
            end
            addr = $urandom & ~((32'd1 << size) - 32'd1);
            for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
            wl_mask = 16'd1 << len;
            if ($urandom_range(0, 7) == 0) begin
                m = (17'd1 << (len + 1)) - 17'd1;
                wl_mask = 16'($urandom) & m[15:0];
            end
            axi_write(id, addr, len, size, burst, $urandom_range(0, 2));
            rr_mode = $urandom_range(0, 2);
            axi_read(~id, addr, len, size, burst, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
